mac_seq_top: RTL and testbench

Parametrised multiply/accumulate datapath top: a control FSM fetches two W-bit operands from a constant ROM into a two-entry register file, multiplies them with a W-cycle sequential shift-add unit, and writes the 2W-bit product to a RAM. In accumulate mode it writes the product plus the RAM word already at the target address. Successor to the single-shot combinational-multiplier datapath, with a start/busy/done handshake and a registered RAM read port.

---
 rtl/mac_seq_top.sv | 127 ++++++++++++
 tb/tb_mac_seq_top.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_seq_top.sv
// Sequential multiply/accumulate datapath: ROM operand fetch, W-cycle shift-add
// multiply, and a RAM write (overwrite or accumulate) behind a start/busy/done handshake.
module mac_seq_top #(
  parameter int W  = 4,
  parameter int AW = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            acc,
  input  logic [AW-1:0]   adr1_r,
  input  logic [AW-1:0]   adr2_r,
  input  logic [AW-1:0]   adr_ram,
  input  logic [AW-1:0]   rd_adr,
  output logic [2*W-1:0]  result,
  output logic [2:0]      st_out,
  output logic            busy,
  output logic            done
);

  localparam int CW    = (W > 1) ? $clog2(W) : 1;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LD_A = 3'd1,
    S_LD_B = 3'd2,
    S_MUL  = 3'd3,
    S_WR   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t          r_state, w_next;
  logic [AW-1:0]   r_adr1, r_adr2, r_adr_w;
  logic            r_acc;
  logic [W-1:0]    r_r0, r_r1;
  logic [2*W-1:0]  r_p, r_m;
  logic [CW-1:0]   r_cnt;
  logic [2*W-1:0]  r_ram [DEPTH];
  logic [2*W-1:0]  r_result;
  logic            w_mul_last;

  // Constant ROM: rom[i] = (2^W - 1 - i) mod 2^W, i.e. the bitwise inverse of i in W bits.
  function automatic logic [W-1:0] rom_rd(input logic [AW-1:0] a);
    logic [W-1:0] v;
    v = W'(a);
    return ~v;
  endfunction

  assign w_mul_last = (r_cnt == CW'(W - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_LD_A;
      S_LD_A:  w_next = S_LD_B;
      S_LD_B:  w_next = S_MUL;
      S_MUL:   if (w_mul_last) w_next = S_WR;
      S_WR:    w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_adr1  <= '0;
      r_adr2  <= '0;
      r_adr_w <= '0;
      r_acc   <= 1'b0;
      r_r0    <= '0;
      r_r1    <= '0;
      r_p     <= '0;
      r_m     <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_adr1  <= adr1_r;
          r_adr2  <= adr2_r;
          r_adr_w <= adr_ram;
          r_acc   <= acc;
        end
        S_LD_A: begin
          r_r0 <= rom_rd(r_adr1);
          r_p  <= '0;
        end
        S_LD_B: begin
          r_r1  <= rom_rd(r_adr2);
          r_m   <= {{W{1'b0}}, r_r0};
          r_cnt <= '0;
        end
        // One shift-add step per cycle, multiplier bits consumed LSB first.
        S_MUL: begin
          if (r_r1[0]) r_p <= r_p + r_m;
          r_m   <= r_m << 1;
          r_r1  <= r_r1 >> 1;
          r_cnt <= r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Read port registers the old word, so a same-address write shows up one edge later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_ram[i] <= '0;
      r_result <= '0;
    end else begin
      r_result <= r_ram[rd_adr];
      if (r_state == S_WR)
        r_ram[r_adr_w] <= r_acc ? (r_ram[r_adr_w] + r_p) : r_p;
    end
  end

  assign result = r_result;
  assign st_out = r_state;
  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);

endmodule

// File: tb/tb_mac_seq_top.sv
// Bench for mac_seq_top: one W=4/AW=3 and one W=8/AW=4 instance, each checked every cycle
// against a timeline model built from the start-edge schedule and plain a*b arithmetic.
module tb_mac_seq_top;

  logic       clk;
  logic       rst;
  logic [1:0] start_v, acc_v;
  logic [3:0] a1_v [2];
  logic [3:0] a2_v [2];
  logic [3:0] wa_v [2];
  logic [3:0] rd_v [2];

  logic [7:0]  res0;
  logic [15:0] res1;
  logic [2:0]  st0, st1;
  logic        busy0, busy1, done0, done1;

  int n_tests = 0;
  int n_fail  = 0;

  mac_seq_top #(.W(4), .AW(3)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .acc(acc_v[0]),
    .adr1_r(a1_v[0][2:0]), .adr2_r(a2_v[0][2:0]), .adr_ram(wa_v[0][2:0]),
    .rd_adr(rd_v[0][2:0]), .result(res0), .st_out(st0), .busy(busy0), .done(done0)
  );

  mac_seq_top #(.W(8), .AW(4)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .acc(acc_v[1]),
    .adr1_r(a1_v[1]), .adr2_r(a2_v[1]), .adr_ram(wa_v[1]),
    .rd_adr(rd_v[1]), .result(res1), .st_out(st1), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // m_t = edges elapsed since the accepted start edge (-1 when idle).
  int m_t    [2];
  int m_prod [2];
  int m_wa   [2];
  int m_acc  [2];
  int m_res  [2];
  int m_ram  [2][16];

  function automatic int wid(input int d);
    return (d != 0) ? 8 : 4;
  endfunction

  function automatic int awid(input int d);
    return (d != 0) ? 4 : 3;
  endfunction

  function automatic int rom(input int w, input int i);
    return ((1 << w) - 1 - i) & ((1 << w) - 1);
  endfunction

  function automatic int exp_st(input int t, input int w);
    if (t < 0)          return 0;
    else if (t == 0)    return 1;
    else if (t == 1)    return 2;
    else if (t <= w + 1) return 3;
    else if (t == w + 2) return 4;
    else                return 5;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        m_t[d]   = -1;
        m_res[d] = 0;
        for (int i = 0; i < 16; i++) m_ram[d][i] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        int w, am, pm;
        w  = wid(d);
        am = (1 << awid(d)) - 1;
        pm = (1 << (2 * w)) - 1;
        m_res[d] = m_ram[d][int'(rd_v[d]) & am];
        if (m_t[d] < 0) begin
          if (start_v[d]) begin
            m_prod[d] = rom(w, int'(a1_v[d]) & am) * rom(w, int'(a2_v[d]) & am);
            m_wa[d]   = int'(wa_v[d]) & am;
            m_acc[d]  = int'(acc_v[d]);
            m_t[d]    = 0;
          end
        end else begin
          if (m_t[d] == w + 2)
            m_ram[d][m_wa[d]] = (m_acc[d] != 0) ? ((m_ram[d][m_wa[d]] + m_prod[d]) & pm) : m_prod[d];
          if (m_t[d] == w + 3) m_t[d] = -1;
          else                 m_t[d] = m_t[d] + 1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int w;
      w = wid(d);
      chk($sformatf("d%0d st_out", d), (d != 0) ? st1 : st0, exp_st(m_t[d], w));
      chk($sformatf("d%0d busy", d), (d != 0) ? busy1 : busy0, (m_t[d] >= 0) ? 1 : 0);
      chk($sformatf("d%0d done", d), (d != 0) ? done1 : done0, (m_t[d] == w + 3) ? 1 : 0);
      chk($sformatf("d%0d result", d), (d != 0) ? res1 : {8'h00, res0}, m_res[d]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic run(input int d, input int a1, input int a2, input int wa, input int ac,
                     output int lat);
    @(negedge clk);
    a1_v[d]    = 4'(a1);
    a2_v[d]    = 4'(a2);
    wa_v[d]    = 4'(wa);
    rd_v[d]    = 4'(wa);
    acc_v[d]   = 1'(ac);
    start_v[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[d] = 1'b0;
    lat = 0;
    while (!((d != 0) ? done1 : done0) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    @(negedge clk);
  endtask

  initial begin
    int lat;
    rst     = 1'b0;
    start_v = '0;
    acc_v   = '0;
    for (int d = 0; d < 2; d++) begin
      a1_v[d] = '0; a2_v[d] = '0; wa_v[d] = '0; rd_v[d] = '0;
    end
    repeat (3) @(negedge clk);
    chk("reset st_out", st0, 0);
    chk("reset busy", busy0, 0);
    chk("reset done", done0, 0);
    chk("reset result", res0, 0);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rd_v[0] = 4'(i);
      @(negedge clk);
      chk($sformatf("reset ram[%0d]", i), res0, 0);
    end

    run(0, 0, 1, 2, 0, lat);
    chk("W4 done latency", lat, 7);
    chk("W4 15x14", res0, 210);
    run(0, 0, 1, 2, 1, lat);
    chk("W4 acc 210+210", res0, 164);
    run(0, 7, 7, 3, 0, lat);
    chk("W4 8x8 square", res0, 64);

    // Inputs churn while busy; only the values latched at start may matter.
    @(negedge clk);
    a1_v[0] = 4'd2; a2_v[0] = 4'd3; wa_v[0] = 4'd4; rd_v[0] = 4'd4;
    acc_v[0] = 1'b0; start_v[0] = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start_v[0] = 1'(i % 2);
      a1_v[0]  = 4'($urandom_range(0, 15));
      a2_v[0]  = 4'($urandom_range(0, 15));
      wa_v[0]  = 4'($urandom_range(0, 15));
      rd_v[0]  = 4'($urandom_range(0, 15));
      acc_v[0] = 1'($urandom_range(0, 1));
      chk("busy held", busy0, 1);
    end
    @(negedge clk);
    start_v[0] = 1'b0;
    rd_v[0] = 4'd4;
    lat = 0;
    while (!done0 && lat < 20) begin
      chk("busy until done", busy0, 1);
      @(negedge clk);
      lat++;
    end
    chk("done reached", done0, 1);
    @(negedge clk);
    chk("latched 13x12", res0, 156);
    chk("idle after run", busy0, 0);

    // Reset in the middle of an accumulate into a populated word.
    run(0, 0, 1, 5, 0, lat);
    chk("ram5 before reset", res0, 210);
    @(negedge clk);
    a1_v[0] = 4'd0; a2_v[0] = 4'd1; wa_v[0] = 4'd5; acc_v[0] = 1'b1; start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    lat = 0;
    while (st0 != 3'd3 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("reached MUL", st0, 3);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async reset st_out", st0, 0);
    chk("async reset busy", busy0, 0);
    @(negedge clk);
    rst = 1'b1;
    rd_v[0] = 4'd5;
    repeat (2) @(negedge clk);
    chk("ram5 after reset", res0, 0);

    run(1, 0, 0, 0, 0, lat);
    chk("W8 done latency", lat, 11);
    chk("W8 255x255", res1, 65025);
    run(1, 0, 0, 0, 1, lat);
    chk("W8 acc wrap", res1, 64514);

    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        start_v[d] = ($urandom_range(0, 3) == 0);
        acc_v[d]   = 1'($urandom_range(0, 1));
        a1_v[d]    = 4'($urandom_range(0, 15));
        a2_v[d]    = 4'($urandom_range(0, 15));
        wa_v[d]    = 4'($urandom_range(0, 15));
        rd_v[d]    = 4'($urandom_range(0, 15));
      end
    end
    @(negedge clk);
    start_v = '0;
    repeat (15) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
